// File: rtl/bus_responder.sv
// CPU bus responder: RAM plus STATUS/RXDATA/TXDATA/IRQEN registers over RX/TX byte FIFOs.
// Reads are combinational from address_bus; writes, FIFO moves and irq update on posedge clk.

module bus_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             empty_o,
  output logic             full_o
);
  localparam int IW = $clog2(DEPTH);

  logic [IW:0]      wr_ptr_q, wr_ptr_d;
  logic [IW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  // The extra pointer bit separates full from empty when the indices coincide.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]) && (wr_ptr_q[IW] != rd_ptr_q[IW]);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q[IW-1:0]];

  assign wr_ptr_d = wr_ptr_q + (IW+1)'(do_push);
  assign rd_ptr_d = rd_ptr_q + (IW+1)'(do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[IW-1:0]] <= push_dat_i;
  end
endmodule

module bus_responder #(
  parameter int          RAM_WORDS  = 2048,
  parameter logic [15:0] IO_BASE    = 16'hFF00,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] address_bus,
  inout  wire  [15:0] data_bus,
  input  logic        r,
  input  logic        w,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        irq
);
  localparam int          AW        = $clog2(RAM_WORDS);
  localparam logic [15:0] A_STATUS  = IO_BASE;
  localparam logic [15:0] A_RXDATA  = IO_BASE + 16'd1;
  localparam logic [15:0] A_TXDATA  = IO_BASE + 16'd2;
  localparam logic [15:0] A_IRQEN   = IO_BASE + 16'd3;

  logic [15:0] ram_q [RAM_WORDS];
  logic        ram_hit, sel_status, sel_rxd, sel_txd, sel_irqen;
  logic        rd_cyc;
  logic        mapped, drive_en;
  logic [15:0] rd_dat;

  logic [7:0]  rx_head;
  logic        rx_empty, rx_full, tx_empty, tx_full;
  logic        overrun_q;
  logic [1:0]  irqen_q;
  logic        irq_q;

  assign ram_hit    = ({1'b0, address_bus} < 17'(RAM_WORDS));
  assign sel_status = (address_bus == A_STATUS);
  assign sel_rxd    = (address_bus == A_RXDATA);
  assign sel_txd    = (address_bus == A_TXDATA);
  assign sel_irqen  = (address_bus == A_IRQEN);

  // A write strobe masks any simultaneous read: no drive, no pop.
  assign rd_cyc = r & ~w;

  always_ff @(posedge clk) begin
    if (w && ram_hit) ram_q[address_bus[AW-1:0]] <= data_bus;
  end

  bus_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (rx_valid),
    .push_dat_i (rx_data),
    .pop_i      (rd_cyc & sel_rxd),
    .head_o     (rx_head),
    .empty_o    (rx_empty),
    .full_o     (rx_full)
  );

  bus_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (w & sel_txd),
    .push_dat_i (data_bus[7:0]),
    .pop_i      (tx_ready),
    .head_o     (tx_data),
    .empty_o    (tx_empty),
    .full_o     (tx_full)
  );

  assign rx_ready = ~rx_full;
  assign tx_valid = ~tx_empty;

  // A new overrun wins over a same-cycle clear so the event is never lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun_q <= 1'b0;
      irqen_q   <= 2'b00;
      irq_q     <= 1'b0;
    end else begin
      if (rx_valid && rx_full)                 overrun_q <= 1'b1;
      else if (w && sel_status && data_bus[4]) overrun_q <= 1'b0;
      if (w && sel_irqen) irqen_q <= data_bus[1:0];
      irq_q <= (irqen_q[0] & ~rx_empty) | (irqen_q[1] & tx_empty);
    end
  end

  assign irq = irq_q;

  always_comb begin
    rd_dat = 16'h0000;
    mapped = ram_hit | sel_status | sel_rxd | sel_txd | sel_irqen;
    if (ram_hit)        rd_dat = ram_q[address_bus[AW-1:0]];
    else if (sel_status) rd_dat = {11'b0, overrun_q, tx_full, ~tx_empty, rx_full, ~rx_empty};
    else if (sel_rxd)   rd_dat = rx_empty ? 16'h0000 : {8'h00, rx_head};
    else if (sel_irqen) rd_dat = {14'b0, irqen_q};
  end

  assign drive_en = rd_cyc & mapped & ~reset;
  assign data_bus = drive_en ? rd_dat : 16'hzzzz;
endmodule

// File: tb/tb_bus_responder.sv
// Scoreboard bench for bus_responder: stimulus queues expectations, a negedge monitor compares them.
// The data bus is pulled up, so an undriven bus reads as 16'hFFFF.

module tb_bus_responder;
  localparam logic [15:0] A_STATUS = 16'hFF00;
  localparam logic [15:0] A_RXD    = 16'hFF01;
  localparam logic [15:0] A_TXD    = 16'hFF02;
  localparam logic [15:0] A_IRQEN  = 16'hFF03;
  localparam logic [15:0] UNDRIVEN = 16'hFFFF;

  typedef enum int {S_DATA, S_RXRDY, S_TXVLD, S_TXDAT, S_IRQ} sig_e;
  typedef struct {
    int          cyc;
    sig_e        sig;
    logic [15:0] val;
    string       name;
  } chk_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] address_bus = 16'h0000;
  wire  [15:0] data_bus;
  logic [15:0] cpu_dat = 16'h0000;
  logic        cpu_drv = 1'b0;
  logic        r = 1'b0;
  logic        w = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        irq;

  chk_t        chkq[$];
  logic [7:0]  txq[$];
  logic [7:0]  rxm[$];
  chk_t        mon_e;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  assign data_bus = cpu_drv ? cpu_dat : 16'hzzzz;
  for (genvar gi = 0; gi < 16; gi++) begin : g_pu
    pullup (data_bus[gi]);
  end

  bus_responder #(.RAM_WORDS(2048), .IO_BASE(16'hFF00), .FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .address_bus (address_bus),
    .data_bus    (data_bus),
    .r           (r),
    .w           (w),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .irq         (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] obs(input sig_e s);
    case (s)
      S_DATA:  return data_bus;
      S_RXRDY: return {15'b0, rx_ready};
      S_TXVLD: return {15'b0, tx_valid};
      S_TXDAT: return {8'h00, tx_data};
      default: return {15'b0, irq};
    endcase
  endfunction

  always @(negedge clk) begin
    while (chkq.size() != 0 && chkq[0].cyc <= cyc) begin
      mon_e = chkq.pop_front();
      check(mon_e.name, obs(mon_e.sig), mon_e.val);
    end
    if (!reset && tx_valid && tx_ready) begin
      if (txq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL tx_unexpected: got byte %h, required no transfer", tx_data);
      end else begin
        check("tx_byte", {8'h00, tx_data}, {8'h00, txq.pop_front()});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_now(input sig_e s, input logic [15:0] v, input string n);
    chk_t e;
    e.cyc = cyc; e.sig = s; e.val = v; e.name = n;
    chkq.push_back(e);
  endtask

  task automatic bus_idle();
    r = 1'b0; w = 1'b0; cpu_drv = 1'b0;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [15:0] d);
    address_bus = a; cpu_dat = d; cpu_drv = 1'b1; w = 1'b1; r = 1'b0;
    step();
    bus_idle();
  endtask

  task automatic cpu_read(input logic [15:0] a, input logic [15:0] exp, input string n);
    address_bus = a; cpu_drv = 1'b0; w = 1'b0; r = 1'b1;
    expect_now(S_DATA, exp, n);
    step();
    r = 1'b0;
  endtask

  task automatic rx_push(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  initial begin
    // Reset state, including a read attempt while reset is high.
    step();
    address_bus = A_STATUS; r = 1'b1;
    expect_now(S_DATA, UNDRIVEN, "rst_bus_z");
    expect_now(S_RXRDY, 16'd1, "rst_rx_ready");
    expect_now(S_TXVLD, 16'd0, "rst_tx_valid");
    expect_now(S_IRQ, 16'd0, "rst_irq");
    step();
    r = 1'b0;
    step();
    reset = 1'b0;
    step();

    // RAM boundary, unmapped space, and read+write collision.
    cpu_write(16'h0000, 16'h1234);
    cpu_write(16'h07FF, 16'hBEEF);
    cpu_read(16'h07FF, 16'hBEEF, "ram_top");
    cpu_read(16'h0800, UNDRIVEN, "ram_past_end_z");
    cpu_read(16'h0000, 16'h1234, "ram_zero");
    cpu_read(16'hFF04, UNDRIVEN, "unmapped_z");
    address_bus = 16'h07FF; cpu_dat = 16'h5A5A; cpu_drv = 1'b1; r = 1'b1; w = 1'b1;
    expect_now(S_DATA, 16'h5A5A, "rw_no_drive");
    step();
    bus_idle();
    cpu_read(16'h07FF, 16'h5A5A, "rw_write_wins");

    // RX fill, overrun, drain, overrun clear.
    for (int i = 0; i < 4; i++) rx_push(8'(17 * (i + 1)));
    expect_now(S_RXRDY, 16'd0, "rx_full_ready");
    rx_push(8'h55);
    cpu_read(A_STATUS, 16'h0013, "status_full_ovr");
    address_bus = A_RXD; cpu_dat = 16'h0000; cpu_drv = 1'b1; r = 1'b1; w = 1'b1;
    step();
    bus_idle();
    for (int i = 0; i < 4; i++) cpu_read(A_RXD, 16'(17 * (i + 1)), "rxd_drain");
    cpu_read(A_STATUS, 16'h0010, "status_ovr_only");
    cpu_read(A_RXD, 16'h0000, "rxd_empty");
    cpu_write(A_STATUS, 16'hFFEF);
    cpu_read(A_STATUS, 16'h0010, "ovr_kept");
    cpu_write(A_STATUS, 16'h0010);
    cpu_read(A_STATUS, 16'h0000, "ovr_cleared");

    // Push and pop together on a full RX FIFO: push refused, overrun set.
    for (int i = 0; i < 4; i++) rx_push(8'h21 + 8'(i));
    rx_data = 8'h25; rx_valid = 1'b1; address_bus = A_RXD; r = 1'b1;
    expect_now(S_DATA, 16'h0021, "full_pushpop_head");
    step();
    rx_valid = 1'b0; r = 1'b0;
    cpu_read(A_STATUS, 16'h0011, "full_pushpop_status");
    for (int i = 0; i < 3; i++) cpu_read(A_RXD, 16'h0022 + 16'(i), "full_pushpop_rest");
    cpu_read(A_RXD, 16'h0000, "full_pushpop_no25");
    cpu_write(A_STATUS, 16'h0010);

    // Push and pop together on an empty RX FIFO: only the push happens.
    rx_data = 8'h77; rx_valid = 1'b1; address_bus = A_RXD; r = 1'b1;
    expect_now(S_DATA, 16'h0000, "empty_pushpop_read");
    step();
    rx_valid = 1'b0; r = 1'b0;
    cpu_read(A_RXD, 16'h0077, "empty_pushpop_kept");
    cpu_read(A_STATUS, 16'h0000, "empty_pushpop_drained");

    // RX-nonempty interrupt.
    cpu_write(A_IRQEN, 16'h0001);
    rx_push(8'h66);
    expect_now(S_IRQ, 16'd0, "irq_not_yet");
    step();
    expect_now(S_IRQ, 16'd1, "irq_rx");
    cpu_read(A_IRQEN, 16'h0001, "irqen_rd");
    cpu_read(A_RXD, 16'h0066, "irq_rx_byte");
    expect_now(S_IRQ, 16'd1, "irq_hold");
    step();
    expect_now(S_IRQ, 16'd0, "irq_rx_clear");

    // TX path and TX-empty interrupt.
    tx_ready = 1'b0;
    cpu_write(A_TXD, 16'h00A1); txq.push_back(8'hA1);
    cpu_write(A_TXD, 16'h00A2); txq.push_back(8'hA2);
    expect_now(S_TXVLD, 16'd1, "tx_valid_set");
    expect_now(S_TXDAT, 16'h00A1, "tx_head");
    cpu_write(A_IRQEN, 16'h0002);
    step();
    expect_now(S_IRQ, 16'd0, "irq_tx_busy");
    tx_ready = 1'b1;
    step();
    step();
    tx_ready = 1'b0;
    expect_now(S_TXVLD, 16'd0, "tx_drained");
    expect_now(S_IRQ, 16'd0, "irq_tx_lag");
    step();
    expect_now(S_IRQ, 16'd1, "irq_tx_empty");

    // TX full: fifth write dropped.
    for (int i = 0; i < 4; i++) begin
      cpu_write(A_TXD, 16'h00B1 + 16'(i));
      txq.push_back(8'hB1 + 8'(i));
    end
    cpu_write(A_TXD, 16'h00B5);
    cpu_read(A_STATUS, 16'h000C, "status_tx_full");
    cpu_read(A_TXD, 16'h0000, "txd_reads_zero");
    tx_ready = 1'b1;
    repeat (5) step();
    tx_ready = 1'b0;
    expect_now(S_TXVLD, 16'd0, "tx_full_drained");

    // Steady push/pop with two entries held: order kept across pointer wraps.
    rx_push(8'h01); rxm.push_back(8'h01);
    rx_push(8'h02); rxm.push_back(8'h02);
    for (int i = 0; i < 10; i++) begin
      rx_data = 8'h03 + 8'(i); rx_valid = 1'b1; address_bus = A_RXD; r = 1'b1;
      expect_now(S_DATA, {8'h00, rxm.pop_front()}, "wrap_pop");
      rxm.push_back(8'h03 + 8'(i));
      step();
    end
    rx_valid = 1'b0; r = 1'b0;
    cpu_read(A_STATUS, 16'h0001, "wrap_status");
    cpu_read(A_RXD, {8'h00, rxm.pop_front()}, "wrap_tail0");
    cpu_read(A_RXD, {8'h00, rxm.pop_front()}, "wrap_tail1");
    cpu_read(A_RXD, 16'h0000, "wrap_empty");

    // Asynchronous reset with both FIFOs loaded and IRQEN=3.
    cpu_write(16'h0010, 16'hCAFE);
    rx_push(8'h99);
    cpu_write(A_TXD, 16'h00D1); txq.push_back(8'hD1);
    cpu_write(A_IRQEN, 16'h0003);
    step();
    expect_now(S_IRQ, 16'd1, "irq_pre_reset");
    expect_now(S_TXVLD, 16'd1, "txvld_pre_reset");
    @(negedge clk);
    #1;
    reset = 1'b1;
    txq.delete();
    #1;
    check("rst_async_rx_ready", {15'b0, rx_ready}, 16'd1);
    check("rst_async_tx_valid", {15'b0, tx_valid}, 16'd0);
    check("rst_async_irq", {15'b0, irq}, 16'd0);
    step();
    step();
    reset = 1'b0;
    step();
    cpu_read(16'h0010, 16'hCAFE, "ram_survives_reset");
    cpu_read(A_STATUS, 16'h0000, "status_after_reset");
    cpu_read(A_IRQEN, 16'h0000, "irqen_after_reset");
    expect_now(S_IRQ, 16'd0, "irq_after_reset");
    expect_now(S_TXVLD, 16'd0, "txvld_after_reset");
    step();
    step();

    if (chkq.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL chk_drain: got %0d pending checks, required 0", chkq.size());
    end
    if (txq.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL tx_drain: got %0d undelivered bytes, required 0", txq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
